// File: rtl/cpu_trace_pkg.sv
// Package: cpu_trace_pkg
// Shared types and constants for the CPU trace-line checker.
//   state_t      : parser state encoding
//   FMT_*        : values driven on format_type
//   ERR_*        : bit positions inside err_code
//   CH_*         : ASCII characters used by the trace grammar
//   max3()       : helper for sizing the shared digit counter
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_COLON_SP,
    S_DOLLAR,
    S_REG,
    S_STAR,
    S_ADDR,
    S_PRE_LT,
    S_LT,
    S_EQ_SP,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;
  localparam logic [1:0] FMT_ERR  = 2'b11;

  localparam int ERR_PC_RANGE   = 0;
  localparam int ERR_PC_ALIGN   = 1;
  localparam int ERR_REG        = 2;
  localparam int ERR_ADDR_ALIGN = 3;

  localparam logic [7:0] CH_CARET  = 8'h5E;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3A;  // ':'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2A;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3C;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3D;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trace_char_classify.sv
// Module: trace_char_classify
// Combinational character classifier for the trace parser.
// Ports:
//   char    in  8  ASCII character
//   is_dec  out 1  char is '0'-'9'
//   is_hex  out 1  char is '0'-'9', 'a'-'f' (and 'A'-'F' when ALLOW_UPPER=1)
//   nibble  out 4  value of the digit (0 when not a digit)
module trace_char_classify
  import cpu_trace_pkg::*;
#(
  parameter bit ALLOW_UPPER = 1'b0
) (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic dec_range;
  logic lower_range;
  logic upper_ok;

  assign dec_range   = (char >= 8'h30) && (char <= 8'h39);
  assign lower_range = (char >= 8'h61) && (char <= 8'h66);

  generate
    if (ALLOW_UPPER) begin : g_upper
      assign upper_ok = (char >= 8'h41) && (char <= 8'h46);
    end else begin : g_no_upper
      assign upper_ok = 1'b0;
    end
  endgenerate

  assign is_dec = dec_range;
  assign is_hex = dec_range || lower_range || upper_ok;

  // 'a'/'A' have low nibble 1, so letters map to low nibble + 9.
  always_comb begin
    nibble = 4'h0;
    if (dec_range) begin
      nibble = char[3:0];
    end else if (lower_range || upper_ok) begin
      nibble = char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// Module: cpu_trace_checker
// Streams one ASCII char per clock and recognises CPU trace lines
//   register write: "^T@PC: $R <= D#"   memory write: "^T@PC: *A <= D#"
// and flags semantic problems (PC range/alignment, GRF index, address alignment).
// Ports:
//   clk          in   1  clock
//   reset        in   1  synchronous active-high reset, overrides char
//   char         in   8  ASCII input
//   format_type  out  2  00 none, 01 reg ok, 10 mem ok, 11 well-formed with semantic error
//   err_code     out  4  [0] PC range, [1] PC align, [2] R>31, [3] A align (only when format_type==11)
// Optional (macro CPU_TRACE_FIELDS_EN): time_val (BCD), pc_val, tgt_val, data_val; zero unless
// a line is being reported.
// Results are Moore outputs: they are valid for exactly the one cycle after '#' is sampled.
// PC range compare assumes HEX_DIGITS <= 16.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 4,
  parameter int          HEX_DIGITS  = 8,
  parameter logic [31:0] PC_MIN      = 32'h0000_3000,
  parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
  parameter bit          ALLOW_UPPER = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              char,
`ifdef CPU_TRACE_FIELDS_EN
  output logic [4*TIME_DIGITS-1:0] time_val,
  output logic [4*HEX_DIGITS-1:0]  pc_val,
  output logic [4*HEX_DIGITS-1:0]  tgt_val,
  output logic [4*HEX_DIGITS-1:0]  data_val,
`endif
  output logic [1:0]              format_type,
  output logic [3:0]              err_code
);

  localparam int AW   = 4 * HEX_DIGITS;
  localparam int MAXD = max3(TIME_DIGITS, REG_DIGITS, HEX_DIGITS);
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW-1:0] TIME_LAST = CW'(TIME_DIGITS);
  localparam logic [CW-1:0] REG_LAST  = CW'(REG_DIGITS);
  localparam logic [CW-1:0] HEX_LAST  = CW'(HEX_DIGITS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic       is_dec;
  logic       is_hex;
  logic [3:0] nibble;

  trace_char_classify #(
    .ALLOW_UPPER(ALLOW_UPPER)
  ) u_classify (
    .char  (char),
    .is_dec(is_dec),
    .is_hex(is_hex),
    .nibble(nibble)
  );

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg,   cnt_next;
  logic [AW-1:0]   pc_reg,    pc_next;
  logic [AW-1:0]   addr_reg,  addr_next;
  logic [5:0]      r_reg,     r_next;
  logic            mem_reg,   mem_next;
  logic [3:0]      err_reg,   err_next;
`ifdef CPU_TRACE_FIELDS_EN
  logic [4*TIME_DIGITS-1:0] time_reg, time_next;
  logic [AW-1:0]            data_reg, data_next;
`endif

  // R = R*10 + d, saturating at 63: anything above 31 is already an error.
  logic [9:0] r_acc;
  logic [5:0] r_sat;
  assign r_acc = (10'(r_reg) * 10'd10) + 10'(nibble);
  assign r_sat = (r_acc > 10'd63) ? 6'd63 : r_acc[5:0];

  logic [AW-1:0] pc_shift;
  logic [AW-1:0] addr_shift;
  assign pc_shift   = (pc_reg << 4) | AW'(nibble);
  assign addr_shift = (addr_reg << 4) | AW'(nibble);

  logic [63:0] pc_ext;
  assign pc_ext = 64'(pc_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      pc_reg    <= '0;
      addr_reg  <= '0;
      r_reg     <= '0;
      mem_reg   <= 1'b0;
      err_reg   <= '0;
`ifdef CPU_TRACE_FIELDS_EN
      time_reg  <= '0;
      data_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      r_reg     <= r_next;
      mem_reg   <= mem_next;
      err_reg   <= err_next;
`ifdef CPU_TRACE_FIELDS_EN
      time_reg  <= time_next;
      data_reg  <= data_next;
`endif
    end
  end

  // Next-state: anything not explicitly accepted falls back to IDLE.
  // A digit arriving when its field is already full also lands in IDLE,
  // so counters never increment past their field length.
  always_comb begin
    state_next = S_IDLE;
    cnt_next   = cnt_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    r_next     = r_reg;
    mem_next   = mem_reg;
    err_next   = err_reg;
`ifdef CPU_TRACE_FIELDS_EN
    time_next  = time_reg;
    data_next  = data_reg;
`endif

    if (char == CH_CARET) begin
      // Restart from any state, discarding everything gathered so far.
      state_next = S_CARET;
      cnt_next   = '0;
      pc_next    = '0;
      addr_next  = '0;
      r_next     = '0;
      mem_next   = 1'b0;
      err_next   = '0;
`ifdef CPU_TRACE_FIELDS_EN
      time_next  = '0;
      data_next  = '0;
`endif
    end else begin
      case (state_reg)
        S_CARET: begin
          if (is_dec) begin
            state_next = S_TIME;
            cnt_next   = CNT_ONE;
`ifdef CPU_TRACE_FIELDS_EN
            time_next  = (time_reg << 4) | (4 * TIME_DIGITS)'(nibble);
`endif
          end
        end
        S_TIME: begin
          if (is_dec && cnt_reg != TIME_LAST) begin
            state_next = S_TIME;
            cnt_next   = cnt_reg + CNT_ONE;
`ifdef CPU_TRACE_FIELDS_EN
            time_next  = (time_reg << 4) | (4 * TIME_DIGITS)'(nibble);
`endif
          end else if (char == CH_AT) begin
            state_next = S_AT;
          end
        end
        S_AT: begin
          if (is_hex) begin
            state_next = S_PC;
            cnt_next   = CNT_ONE;
            pc_next    = pc_shift;
          end
        end
        S_PC: begin
          if (is_hex && cnt_reg != HEX_LAST) begin
            state_next = S_PC;
            cnt_next   = cnt_reg + CNT_ONE;
            pc_next    = pc_shift;
          end else if (char == CH_COLON && cnt_reg == HEX_LAST) begin
            state_next = S_COLON_SP;
          end
        end
        S_COLON_SP: begin
          if (char == CH_SPACE) begin
            state_next = S_COLON_SP;
          end else if (char == CH_DOLLAR) begin
            state_next = S_DOLLAR;
            mem_next   = 1'b0;
          end else if (char == CH_STAR) begin
            state_next = S_STAR;
            mem_next   = 1'b1;
          end
        end
        S_DOLLAR: begin
          if (is_dec) begin
            state_next = S_REG;
            cnt_next   = CNT_ONE;
            r_next     = {2'b00, nibble};
          end
        end
        S_REG: begin
          if (is_dec && cnt_reg != REG_LAST) begin
            state_next = S_REG;
            cnt_next   = cnt_reg + CNT_ONE;
            r_next     = r_sat;
          end else if (char == CH_SPACE) begin
            state_next = S_PRE_LT;
          end else if (char == CH_LT) begin
            state_next = S_LT;
          end
        end
        S_STAR: begin
          if (is_hex) begin
            state_next = S_ADDR;
            cnt_next   = CNT_ONE;
            addr_next  = addr_shift;
          end
        end
        S_ADDR: begin
          if (is_hex && cnt_reg != HEX_LAST) begin
            state_next = S_ADDR;
            cnt_next   = cnt_reg + CNT_ONE;
            addr_next  = addr_shift;
          end else if (char == CH_SPACE && cnt_reg == HEX_LAST) begin
            state_next = S_PRE_LT;
          end else if (char == CH_LT && cnt_reg == HEX_LAST) begin
            state_next = S_LT;
          end
        end
        S_PRE_LT: begin
          if (char == CH_SPACE) begin
            state_next = S_PRE_LT;
          end else if (char == CH_LT) begin
            state_next = S_LT;
          end
        end
        S_LT: begin
          if (char == CH_EQ) begin
            state_next = S_EQ_SP;
          end
        end
        S_EQ_SP: begin
          if (char == CH_SPACE) begin
            state_next = S_EQ_SP;
          end else if (is_hex) begin
            state_next = S_DATA;
            cnt_next   = CNT_ONE;
`ifdef CPU_TRACE_FIELDS_EN
            data_next  = (data_reg << 4) | AW'(nibble);
`endif
          end
        end
        S_DATA: begin
          if (is_hex && cnt_reg != HEX_LAST) begin
            state_next = S_DATA;
            cnt_next   = cnt_reg + CNT_ONE;
`ifdef CPU_TRACE_FIELDS_EN
            data_next  = (data_reg << 4) | AW'(nibble);
`endif
          end else if (char == CH_HASH && cnt_reg == HEX_LAST) begin
            // Line complete: latch the semantic checks for the DONE cycle.
            state_next                 = S_DONE;
            err_next                   = '0;
            err_next[ERR_PC_RANGE]     = (pc_ext < 64'(PC_MIN)) || (pc_ext > 64'(PC_MAX));
            err_next[ERR_PC_ALIGN]     = |pc_reg[1:0];
            err_next[ERR_REG]          = !mem_reg && (r_reg > 6'd31);
            err_next[ERR_ADDR_ALIGN]   = mem_reg && (|addr_reg[1:0]);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  logic in_done;
  assign in_done = (state_reg == S_DONE);

  always_comb begin
    format_type = FMT_NONE;
    err_code    = 4'h0;
    if (in_done) begin
      err_code = err_reg;
      if (|err_reg) begin
        format_type = FMT_ERR;
      end else if (mem_reg) begin
        format_type = FMT_MEM;
      end else begin
        format_type = FMT_REG;
      end
    end
  end

`ifdef CPU_TRACE_FIELDS_EN
  assign time_val = in_done ? time_reg : '0;
  assign pc_val   = in_done ? pc_reg : '0;
  assign tgt_val  = in_done ? (mem_reg ? addr_reg : AW'(r_reg)) : '0;
  assign data_val = in_done ? data_reg : '0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Testbench for cpu_trace_checker: two instances (ALLOW_UPPER=0 and =1) see the same
// character stream. The stimulus pushes the expected result of every '#' into a
// per-instance queue stamped with the cycle it must appear in; a monitor pops and
// compares whenever an instance reports a line, and flags pulses that never came.
module tb_cpu_trace_checker;
  import cpu_trace_pkg::*;

  typedef struct {
    int         cyc;
    logic [1:0] fmt;
    logic [3:0] err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] char;
  logic [1:0] ft_lo, ft_up;
  logic [3:0] ec_lo, ec_up;
`ifdef CPU_TRACE_FIELDS_EN
  logic [15:0] tv_lo, tv_up;
  logic [31:0] pv_lo, pv_up, gv_lo, gv_up, dv_lo, dv_up;
`endif

  int   pos_cnt;
  int   total;
  int   bad;
  exp_t q_lo[$];
  exp_t q_up[$];

  cpu_trace_checker #(.ALLOW_UPPER(1'b0)) u_lo (
    .clk        (clk),
    .reset      (reset),
    .char       (char),
`ifdef CPU_TRACE_FIELDS_EN
    .time_val   (tv_lo),
    .pc_val     (pv_lo),
    .tgt_val    (gv_lo),
    .data_val   (dv_lo),
`endif
    .format_type(ft_lo),
    .err_code   (ec_lo)
  );

  cpu_trace_checker #(.ALLOW_UPPER(1'b1)) u_up (
    .clk        (clk),
    .reset      (reset),
    .char       (char),
`ifdef CPU_TRACE_FIELDS_EN
    .time_val   (tv_up),
    .pc_val     (pv_up),
    .tgt_val    (gv_up),
    .data_val   (dv_up),
`endif
    .format_type(ft_up),
    .err_code   (ec_up)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  task automatic report_pulse(input string name, input bit have, input exp_t e,
                              input logic [1:0] ft, input logic [3:0] ec);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s unexpected: got fmt=%b err=%b at cyc %0d, required no output",
               name, ft, ec, pos_cnt);
    end else if (e.cyc != pos_cnt || e.fmt != ft || e.err != ec) begin
      bad++;
      $display("FAIL %s line: got fmt=%b err=%b cyc=%0d, required fmt=%b err=%b cyc=%0d",
               name, ft, ec, pos_cnt, e.fmt, e.err, e.cyc);
    end else begin
      $display("ok   %s line: fmt=%b err=%b cyc=%0d", name, ft, ec, pos_cnt);
    end
  endtask

  task automatic report_missed(input string name, input exp_t e);
    total++;
    bad++;
    $display("FAIL %s missing: got no output by cyc %0d, required fmt=%b err=%b at cyc %0d",
             name, pos_cnt, e.fmt, e.err, e.cyc);
  endtask

  task automatic report_stray_err(input string name, input logic [3:0] ec);
    total++;
    bad++;
    $display("FAIL %s err_code: got %b with fmt=00, required 0000", name, ec);
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!reset) begin
      if (q_lo.size() > 0 && q_lo[0].cyc < pos_cnt) begin
        e = q_lo.pop_front();
        report_missed("lo", e);
      end
      if (ft_lo != FMT_NONE) begin
        have = (q_lo.size() > 0);
        e    = '{0, 2'b00, 4'h0};
        if (have) e = q_lo.pop_front();
        report_pulse("lo", have, e, ft_lo, ec_lo);
      end else if (ec_lo != 4'h0) begin
        report_stray_err("lo", ec_lo);
      end

      if (q_up.size() > 0 && q_up[0].cyc < pos_cnt) begin
        e = q_up.pop_front();
        report_missed("up", e);
      end
      if (ft_up != FMT_NONE) begin
        have = (q_up.size() > 0);
        e    = '{0, 2'b00, 4'h0};
        if (have) e = q_up.pop_front();
        report_pulse("up", have, e, ft_up, ec_up);
      end else if (ec_up != 4'h0) begin
        report_stray_err("up", ec_up);
      end
    end
  end

  // Drive one char per falling edge; each '#' queues the expected result for
  // the cycle after it is sampled (fmt 00 means no output is expected).
  task automatic drive_str(input string s,
                           input logic [1:0] fl, input logic [3:0] el,
                           input logic [1:0] fu, input logic [3:0] eu);
    byte c;
    for (int i = 0; i < s.len(); i++) begin
      c    = s[i];
      char = c;
      if (c == CH_HASH) begin
        if (fl != FMT_NONE) q_lo.push_back('{pos_cnt + 1, fl, el});
        if (fu != FMT_NONE) q_up.push_back('{pos_cnt + 1, fu, eu});
      end
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (ft_lo != FMT_NONE || ec_lo != 4'h0 || ft_up != FMT_NONE || ec_up != 4'h0) begin
      bad++;
      $display("FAIL %s: got lo=%b/%b up=%b/%b, required 00/0000", name, ft_lo, ec_lo, ft_up, ec_up);
    end else begin
      $display("ok   %s: outputs idle", name);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    char  = 8'h00;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    reset = 1'b0;

    drive_str("^10@00003010: $1 <= 0000000a#\n",            FMT_REG, 4'b0000, FMT_REG, 4'b0000);
    drive_str("^7@00003000: *00000004 <= ffffffff#\n",       FMT_MEM, 4'b0000, FMT_MEM, 4'b0000);
    drive_str("^10@00002ffc: $32<=00000000#\n",              FMT_ERR, 4'b0101, FMT_ERR, 4'b0101);
    drive_str("^10@00003004: *00000006 <= 00000000#\n",      FMT_ERR, 4'b1000, FMT_ERR, 4'b1000);
    drive_str("^12@^5@00003000: $0   <=   00000000#\n",      FMT_REG, 4'b0000, FMT_REG, 4'b0000);
    drive_str("^12345@00003000: $1 <= 00000000#\n",          FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);
    drive_str("^1@00006ffc: $31 <= 12345678#\n",             FMT_REG, 4'b0000, FMT_REG, 4'b0000);
    drive_str("^1@00007000: *00000008 <= 00000000#\n",       FMT_ERR, 4'b0001, FMT_ERR, 4'b0001);
    drive_str("^1@00003001: *00000002 <= 00000000#\n",       FMT_ERR, 4'b1010, FMT_ERR, 4'b1010);
    drive_str("^1@00003000: $1000 <= 00000000#\n",           FMT_ERR, 4'b0100, FMT_ERR, 4'b0100);
    drive_str("^1@00003000: $12345 <= 00000000#\n",          FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);
    drive_str("^1@0000300: $1 <= 00000000#\n",               FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);
    drive_str("^1@00003000: $1 <= 000000000#\n",             FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);
    drive_str("^1@00003000: $1 <= 0000000A#\n",              FMT_NONE, 4'b0000, FMT_REG, 4'b0000);
    drive_str("^1@00003000: $2 <= 00000001#^1@00003000: $2 <= 00000001#\n",
                                                             FMT_REG, 4'b0000, FMT_REG, 4'b0000);
    drive_str("^1@00003000: $1 <= 0000^2@00003008: *0000000c <= 00000000#\n",
                                                             FMT_MEM, 4'b0000, FMT_MEM, 4'b0000);

    // Reset mid-line: without it the stream would still form a valid line.
    drive_str("^1@0000", FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);
    reset = 1'b1;
    char  = 8'h33;
    @(negedge clk);
    check_quiet("mid_line_reset");
    reset = 1'b0;
    drive_str("0a0: $1 <= 00000000#\n", FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);

    drive_str("\n\n\n", FMT_NONE, 4'b0000, FMT_NONE, 4'b0000);

    total++;
    if (q_lo.size() != 0) begin
      bad++;
      $display("FAIL lo_drain: got %0d pending results, required 0", q_lo.size());
    end
    total++;
    if (q_up.size() != 0) begin
      bad++;
      $display("FAIL up_drain: got %0d pending results, required 0", q_up.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
